// File: rtl/spi_tx_scheduler.sv
// Round-robin frame scheduler sharing one SPI master TX port between two byte-stream requesters.
// Registered outputs, request to first DV in 2 cycles; waits on i_TX_Ready. SPI_SCHED_HEADER_EN adds a 2-byte header.
module spi_tx_scheduler #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [1:0]         i_Req,
  input  logic [2*LEN_W-1:0] i_Len,
  input  logic [15:0]        i_Byte,
  output logic [1:0]         o_Pop,
  output logic [1:0]         o_Done,
  output logic [1:0]         o_Grant,
  output logic               o_Busy,
  output logic [7:0]         o_TX_Byte,
  output logic               o_TX_DV,
  input  logic               i_TX_Ready
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, SEND, HOLD, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             g_q, g_d;
  logic             last_q, last_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       pop_q, pop_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
`ifdef SPI_SCHED_HEADER_EN
  logic [7:0]       hdr_q, hdr_d;
`endif

  logic             win;
  logic [LEN_W-1:0] len_raw;
  logic [LEN_W-1:0] len_clip;
  logic [7:0]       byte_g;
  logic [1:0]       g_onehot;

  always_comb begin
    // A lone requester wins; on a tie the one that did not go last wins.
    win      = (i_Req == 2'b11) ? ~last_q : i_Req[1];
    len_raw  = win ? i_Len[2*LEN_W-1:LEN_W] : i_Len[LEN_W-1:0];
    len_clip = (len_raw > MAX_L) ? MAX_L : len_raw;
    byte_g   = g_q ? i_Byte[15:8] : i_Byte[7:0];
    g_onehot = g_q ? 2'b10 : 2'b01;

    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    g_d       = g_q;
    last_d    = last_q;
    grant_d   = grant_q;
    pop_d     = 2'b00;
    done_d    = 2'b00;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
`ifdef SPI_SCHED_HEADER_EN
    hdr_d     = hdr_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_Req != 2'b00) begin
          g_d     = win;
          cnt_d   = len_clip;
          grant_d = win ? 2'b10 : 2'b01;
`ifdef SPI_SCHED_HEADER_EN
          hdr_d   = {win, 7'(len_clip)};
`endif
          if (len_clip == '0) begin
            state_d = DONE;
          end else begin
`ifdef SPI_SCHED_HEADER_EN
            state_d = HDR0;
`else
            state_d = SEND;
`endif
          end
        end
      end
`ifdef SPI_SCHED_HEADER_EN
      HDR0: begin
        if (i_TX_Ready) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = 8'hA5;
          ret_d     = HDR1;
          state_d   = HOLD;
        end
      end
      HDR1: begin
        if (i_TX_Ready) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = hdr_q;
          ret_d     = SEND;
          state_d   = HOLD;
        end
      end
`endif
      SEND: begin
        if (!i_Req[g_q]) begin
          state_d = DONE;
        end else if (i_TX_Ready) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = byte_g;
          pop_d     = g_onehot;
          cnt_d     = cnt_q - 1'b1;
          ret_d     = (cnt_d != '0) ? SEND : DONE;
          state_d   = HOLD;
        end
      end
      // One dead cycle so the master's Ready deassert is visible before the next strobe.
      HOLD: begin
        state_d = ret_q;
      end
      DONE: begin
        done_d  = g_onehot;
        last_d  = g_q;
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      cnt_q     <= '0;
      g_q       <= 1'b0;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
      pop_q     <= 2'b00;
      done_q    <= 2'b00;
      busy_q    <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
`ifdef SPI_SCHED_HEADER_EN
      hdr_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      pop_q     <= pop_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
`ifdef SPI_SCHED_HEADER_EN
      hdr_q     <= hdr_d;
`endif
    end
  end

  assign o_Pop     = pop_q;
  assign o_Done    = done_q;
  assign o_Grant   = grant_q;
  assign o_Busy    = busy_q;
  assign o_TX_Byte = tx_byte_q;
  assign o_TX_DV   = tx_dv_q;

endmodule
